// File: rtl/audio_pdm_out_pkg.sv
// Shared definitions for the audio PDM output stage: default widths,
// nominal sample-rate divider values, lane offsets inside a stereo frame,
// and the per-tick outcome used to steer the sample hold registers.
package audio_pdm_out_pkg;

   localparam int SW_DEFAULT      = 16;
   localparam int FIFO_AW_DEFAULT = 8;

   // Clocks per sample period at 24 MHz
   localparam int DIV_48K  = 500;
   localparam int DIV_44K1 = 544;

   // Lane index of each channel inside in_data (offset = lane * SW)
   localparam int LANE_LEFT  = 0;
   localparam int LANE_RIGHT = 1;

   typedef enum logic [1:0] {
      TICK_IDLE     = 2'd0,
      TICK_POP      = 2'd1,
      TICK_UNDERRUN = 2'd2
   } tick_kind_e;

endpackage

// File: rtl/audio_dsm.sv
// One-channel delta-sigma modulator producing a 1-bit stream every clock.
// Default build: first-order modulator, the output is the registered carry
// of an SW-bit phase accumulator fed with the offset-binary sample.
// With AUDIO_PDM_ORDER2_EN defined: second-order modulator with two
// saturating SW+4-bit signed integrators and +/-2^(SW-1) feedback.
module audio_dsm #(
   parameter int SW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [SW-1:0] x,
   output logic                 out
);

`ifdef AUDIO_PDM_ORDER2_EN
   localparam int IW = SW + 4;
   localparam logic signed [IW+1:0] I_MAX = {3'b000, {(IW-1){1'b1}}};
   localparam logic signed [IW+1:0] I_MIN = {3'b111, {(IW-1){1'b0}}};

   logic signed [IW-1:0] i1, i2;
   logic signed [IW+1:0] fb, sum1, sum2;

   function automatic logic signed [IW-1:0] sat(input logic signed [IW+1:0] v);
      if (v > I_MAX)
         return I_MAX[IW-1:0];
      else if (v < I_MIN)
         return I_MIN[IW-1:0];
      else
         return v[IW-1:0];
   endfunction

   assign fb   = out ? {{(IW+2-SW){1'b0}}, 1'b1, {(SW-1){1'b0}}}
                     : {{(IW+3-SW){1'b1}}, {(SW-1){1'b0}}};
   assign sum1 = (IW+2)'(i1) + (IW+2)'(x) - fb;
   assign sum2 = (IW+2)'(i2) + (IW+2)'(i1) - fb;

   // Integrator cascade with feedback from the previous output bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1  <= '0;
         i2  <= '0;
         out <= 1'b0;
      end else begin
         i1  <= sat(sum1);
         i2  <= sat(sum2);
         out <= ~i2[IW-1];
      end
   end
`else
   logic [SW:0]   acc;
   logic [SW-1:0] u;

   // Adding 2^(SW-1) modulo 2^SW is the same as flipping the sign bit.
   assign u = x ^ {1'b1, {(SW-1){1'b0}}};

   // Phase accumulator; its carry-out is the density-coded output bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else
         acc <= {1'b0, acc[SW-1:0]} + {1'b0, u};
   end

   assign out = acc[SW];
`endif

endmodule

// File: rtl/audio_pdm_out.sv
// Audio PDM output stage: stereo PCM frames arrive over a valid/ready
// stream into a 2^FIFO_AW deep frame FIFO, one frame is popped per sample
// tick, and each channel drives its pad through a delta-sigma modulator
// running at the system clock rate.
// Optional: AUDIO_PDM_ORDER2_EN selects second-order modulators.
module audio_pdm_out
   import audio_pdm_out_pkg::*;
#(
   parameter int FIFO_AW = FIFO_AW_DEFAULT,
   parameter int SW      = SW_DEFAULT,
   parameter int DIV_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2*SW-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              enable,
   input  logic [DIV_W-1:0]  tick_div,
   output logic [FIFO_AW:0]  level,
   output logic              underrun,
   output logic [1:0]        audio
);

   localparam int DEPTH = 2**FIFO_AW;
   localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW+1)'(DEPTH);

   logic [2*SW-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
   logic [DIV_W-1:0]     tick_cnt, tick_reload;
   logic                 tick, push, pop, fifo_empty;
   tick_kind_e           tick_kind;
   logic signed [SW-1:0] hold_l, hold_r, x_l, x_r;

   // Ready depends only on the registered level, never on in_valid.
   assign in_ready    = (level != LEVEL_FULL);
   assign fifo_empty  = (level == '0);
   assign push        = in_valid & in_ready;
   assign tick_reload = (tick_div > DIV_W'(1)) ? tick_div - DIV_W'(1) : '0;
   assign tick        = enable & (tick_cnt == '0);
   assign pop         = (tick_kind == TICK_POP);

   // Classify each sample tick as a pop or an underrun.
   always_comb begin
      tick_kind = TICK_IDLE;
      if (tick)
         tick_kind = fifo_empty ? TICK_UNDERRUN : TICK_POP;
   end

   // Sample-period down-counter; parked at the reload value while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tick_cnt <= '0;
      else if (!enable || tick)
         tick_cnt <= tick_reload;
      else
         tick_cnt <= tick_cnt - DIV_W'(1);
   end

   // FIFO pointers and occupancy; push and pop together leave level alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (push && !pop)
            level <= level + (FIFO_AW+1)'(1);
         else if (pop && !push)
            level <= level - (FIFO_AW+1)'(1);
      end
   end

   // Frame storage, kept reset-free so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // Load the popped frame (or silence on underrun) into the hold registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_l   <= '0;
         hold_r   <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= (tick_kind == TICK_UNDERRUN);
         case (tick_kind)
            TICK_POP: begin
               hold_l <= mem[rd_ptr][LANE_LEFT*SW +: SW];
               hold_r <= mem[rd_ptr][LANE_RIGHT*SW +: SW];
            end
            TICK_UNDERRUN: begin
               hold_l <= '0;
               hold_r <= '0;
            end
            default: ;
         endcase
      end
   end

   assign x_l = enable ? hold_l : '0;
   assign x_r = enable ? hold_r : '0;

   audio_dsm #(.SW(SW)) u_dsm_l (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x_l),
      .out   (audio[0])
   );

   audio_dsm #(.SW(SW)) u_dsm_r (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x_r),
      .out   (audio[1])
   );

endmodule

// File: tb/tb_audio_pdm_out.sv
// Self-checking bench for audio_pdm_out (default first-order build).
// A frame-level reference model (queue of frames, absolute tick schedule,
// integer phase accumulators) predicts level, in_ready, underrun and audio
// every cycle; directed sequences add fixed expectations for the corners.
module tb_audio_pdm_out;
   import audio_pdm_out_pkg::*;

   localparam int SW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] tick_div = '0;
   logic        in_ready;
   logic [8:0]  level;
   logic        underrun;
   logic [1:0]  audio;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mQ[$];
   int          mHoldL, mHoldR, mAccL, mAccR;
   bit          mOutL, mOutR, mUnderrun;
   longint      mCyc = 0;
   longint      mNextTick = 0;

   // Observations of the DUT, accumulated over a window
   int obsUnderruns, obsOnesL, obsOnesR, obsMaxLevel;

   typedef struct {
      int div;
      int expPeriod;
   } periodVec_t;

   periodVec_t pv[6];

   audio_pdm_out #(.FIFO_AW(AW), .SW(SW), .DIV_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .enable   (enable),
      .tick_div (tick_div),
      .level    (level),
      .underrun (underrun),
      .audio    (audio)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compareTol(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mHoldL = 0; mHoldR = 0;
      mAccL = 0;  mAccR = 0;
      mOutL = 0;  mOutR = 0;
      mUnderrun = 0;
      mNextTick = mCyc;
   endtask

   // Predict the state after the coming clock edge from the current inputs.
   task automatic modelStep(input bit v, input logic [31:0] d, input bit en, input int div);
      int p, xl, xr, sl, sr;
      bit tick, pushOk;
      logic [31:0] f;
      p  = (div <= 1) ? 1 : div;
      xl = en ? mHoldL : 0;
      xr = en ? mHoldR : 0;
      sl = mAccL + xl + 32768;
      sr = mAccR + xr + 32768;
      mOutL = (sl >= 65536);
      mOutR = (sr >= 65536);
      mAccL = sl % 65536;
      mAccR = sr % 65536;
      tick = 0;
      if (!en)
         mNextTick = mCyc + p;
      else if (mCyc == mNextTick) begin
         tick = 1;
         mNextTick = mCyc + p;
      end
      pushOk = v && (mQ.size() < DEPTH);
      mUnderrun = tick && (mQ.size() == 0);
      if (tick) begin
         if (mQ.size() != 0) begin
            f = mQ.pop_front();
            mHoldL = int'($signed(f[15:0]));
            mHoldR = int'($signed(f[31:16]));
         end else begin
            mHoldL = 0;
            mHoldR = 0;
         end
      end
      if (pushOk)
         mQ.push_back(d);
      mCyc++;
   endtask

   task automatic checkOutput();
      compare("level", int'(level), mQ.size());
      compare("in_ready", int'(in_ready), (mQ.size() < DEPTH) ? 1 : 0);
      compare("underrun", int'(underrun), int'(mUnderrun));
      compare("audio", int'(audio), int'({mOutR, mOutL}));
      obsUnderruns += int'(underrun);
      obsOnesL     += int'(audio[0]);
      obsOnesR     += int'(audio[1]);
      if (int'(level) > obsMaxLevel)
         obsMaxLevel = int'(level);
   endtask

   task automatic clearObs();
      obsUnderruns = 0; obsOnesL = 0; obsOnesR = 0; obsMaxLevel = 0;
   endtask

   // Called at a falling edge: drive, predict, clock, then check.
   task automatic applyStimulus(input bit v, input logic [31:0] d, input bit en, input int div);
      in_valid = v;
      in_data  = d;
      enable   = en;
      tick_div = 16'(div);
      modelStep(v, d, en, div);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic runUntilUnderrun(input int div, input int budget, output int n);
      bit seen;
      seen = 0;
      n = -1;
      for (int k = 1; k <= budget && !seen; k++) begin
         applyStimulus(0, '0, 1, div);
         if (underrun) begin
            seen = 1;
            n = k;
         end
      end
   endtask

   initial begin
      #10_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, p, rdiv;
      bit ren;
      logic [31:0] fr;

      pv[0] = '{0, 1};
      pv[1] = '{1, 1};
      pv[2] = '{2, 2};
      pv[3] = '{10, 10};
      pv[4] = '{37, 37};
      pv[5] = '{DIV_44K1, 544};
      clearObs();

      // Reset values
      repeat (2) @(negedge clk);
      compare("reset_level", int'(level), 0);
      compare("reset_in_ready", int'(in_ready), 1);
      compare("reset_underrun", int'(underrun), 0);
      compare("reset_audio", int'(audio), 0);
      rst_n = 1'b1;
      modelReset();

      // Four frames at 48 kHz spacing
      for (int i = 0; i < 4; i++)
         applyStimulus(1, $urandom, 0, DIV_48K);
      clearObs();
      repeat (1200) applyStimulus(0, '0, 1, DIV_48K);
      compare("plan1_level_mid", int'(level), 2);
      repeat (900) applyStimulus(0, '0, 1, DIV_48K);
      compare("plan1_level_end", int'(level), 0);
      compare("plan1_underruns", obsUnderruns, 0);

      // Fill to full while disabled, offer one extra frame, then drain
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1, $urandom, 0, 1);
      compare("fill_level", int'(level), 256);
      compare("fill_in_ready", int'(in_ready), 0);
      applyStimulus(1, 32'hDEAD_BEEF, 0, 1);
      compare("fill_level_extra", int'(level), 256);
      repeat (260) applyStimulus(0, '0, 1, 1);
      compare("drain_level", int'(level), 0);

      // Underrun spacing for a table of divider values
      for (int i = 0; i < 6; i++) begin
         p = (pv[i].div <= 1) ? 1 : pv[i].div;
         runUntilUnderrun(pv[i].div, 3 * p + 600, n);
         runUntilUnderrun(pv[i].div, 3 * p + 600, n);
         runUntilUnderrun(pv[i].div, 3 * p + 600, n);
         compare($sformatf("period_div%0d", pv[i].div), n, pv[i].expPeriod);
      end

      // Silence after underrun gives half density
      clearObs();
      repeat (1024) applyStimulus(0, '0, 1, 10);
      compareTol("density_half_l", obsOnesL, 512, 1);
      compareTol("density_half_r", obsOnesR, 512, 1);

      // Left +16383, right -16384 held for a long sample period
      fr = {16'hC000, 16'h3FFF};
      applyStimulus(1, fr, 0, 2);
      applyStimulus(0, '0, 1, 2);
      applyStimulus(0, '0, 1, 6000);
      compare("lr_popped_level", int'(level), 0);
      clearObs();
      repeat (4096) applyStimulus(0, '0, 1, 6000);
      compareTol("density_075_l", obsOnesL, 3072, 2);
      compareTol("density_025_r", obsOnesR, 1024, 2);
      compare("lr_underruns", obsUnderruns, 0);

      // tick_div=1 with a push every cycle
      applyStimulus(0, '0, 0, 1);
      applyStimulus(1, $urandom, 1, 1);
      clearObs();
      repeat (63) applyStimulus(1, $urandom, 1, 1);
      compare("stream_underruns", obsUnderruns, 0);
      compare("stream_max_level", obsMaxLevel, 1);
      repeat (4) applyStimulus(0, '0, 1, 1);

      // Randomized traffic against the model
      rdiv = 5;
      ren = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0)
            rdiv = $urandom_range(0, 12);
         if ($urandom_range(0, 99) < 2)
            ren = !ren;
         applyStimulus($urandom_range(0, 99) < 55, $urandom, ren, rdiv);
      end
      repeat (300) applyStimulus(0, '0, 1, 1);

      // Asynchronous reset in the middle of playback
      for (int i = 0; i < 37; i++)
         applyStimulus(1, $urandom, 0, DIV_48K);
      compare("prereset_level", int'(level), 37);
      repeat (50) applyStimulus(0, '0, 1, DIV_48K);
      #2;
      rst_n = 1'b0;
      #1;
      compare("midreset_level", int'(level), 0);
      compare("midreset_in_ready", int'(in_ready), 1);
      compare("midreset_underrun", int'(underrun), 0);
      compare("midreset_audio", int'(audio), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1, $urandom, 1, 4);
      repeat (40) applyStimulus(0, '0, 1, 4);
      compare("resume_level", int'(level), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
